// File: rtl/tagged_register_file.sv
// Register file for the dispatch stage. Each register has a value, a busy bit and an owner tag.
// Optional macro RF_BYPASS_EN forwards writes from the same edge to the registered read ports.
module tagged_register_file #(
    parameter int NUM_REGS     = 16,
    parameter int DATA_W       = 16,
    parameter int TAG_W        = 4,
    parameter int READ_PORTS   = 8,
    parameter int ALLOC_PORTS  = 4,
    parameter int RETIRE_PORTS = 4,
    localparam int AW          = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [READ_PORTS*AW-1:0]       rd_addr_flat,
    output logic [READ_PORTS*DATA_W-1:0]   rd_value_flat,
    output logic [READ_PORTS-1:0]          rd_busy_flat,
    output logic [READ_PORTS*TAG_W-1:0]    rd_owner_flat,
    input  logic [ALLOC_PORTS-1:0]         alloc_en_flat,
    input  logic [ALLOC_PORTS*AW-1:0]      alloc_reg_flat,
    input  logic [ALLOC_PORTS*TAG_W-1:0]   alloc_tag_flat,
    input  logic [RETIRE_PORTS-1:0]        ret_en_flat,
    input  logic [RETIRE_PORTS*AW-1:0]     ret_reg_flat,
    input  logic [RETIRE_PORTS*DATA_W-1:0] ret_data_flat,
    input  logic [RETIRE_PORTS*TAG_W-1:0]  ret_tag_flat
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] val_q  [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [TAG_W-1:0]  own_q  [DEPTH];
    logic [DATA_W-1:0] val_n  [DEPTH];
    logic [DEPTH-1:0]  busy_n;
    logic [TAG_W-1:0]  own_n  [DEPTH];
    logic [DATA_W-1:0] src_val [DEPTH];
    logic [DEPTH-1:0]  src_busy;
    logic [TAG_W-1:0]  src_own [DEPTH];
    logic [DEPTH-1:0]  reg_ok;

    logic [AW-1:0]     rd_addr   [READ_PORTS];
    logic [DATA_W-1:0] rd_value_q [READ_PORTS];
    logic [READ_PORTS-1:0] rd_busy_q;
    logic [TAG_W-1:0]  rd_owner_q [READ_PORTS];

    logic [ALLOC_PORTS-1:0]  alloc_en;
    logic [AW-1:0]           alloc_reg [ALLOC_PORTS];
    logic [TAG_W-1:0]        alloc_tag [ALLOC_PORTS];
    logic [RETIRE_PORTS-1:0] ret_en;
    logic [AW-1:0]           ret_reg  [RETIRE_PORTS];
    logic [DATA_W-1:0]       ret_data [RETIRE_PORTS];
    logic [TAG_W-1:0]        ret_tag  [RETIRE_PORTS];

    // Addresses past NUM_REGS map onto storage that is never written, so it reads as zero.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ok
        assign reg_ok[g] = (g < NUM_REGS);
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        assign rd_addr[g] = rd_addr_flat[(READ_PORTS-1-g)*AW +: AW];
        assign rd_value_flat[(READ_PORTS-1-g)*DATA_W +: DATA_W] = rd_value_q[g];
        assign rd_busy_flat[READ_PORTS-1-g] = rd_busy_q[g];
        assign rd_owner_flat[(READ_PORTS-1-g)*TAG_W +: TAG_W] = rd_owner_q[g];
    end

    for (genvar g = 0; g < ALLOC_PORTS; g++) begin : g_alloc
        assign alloc_en[g]  = alloc_en_flat[ALLOC_PORTS-1-g];
        assign alloc_reg[g] = alloc_reg_flat[(ALLOC_PORTS-1-g)*AW +: AW];
        assign alloc_tag[g] = alloc_tag_flat[(ALLOC_PORTS-1-g)*TAG_W +: TAG_W];
    end

    for (genvar g = 0; g < RETIRE_PORTS; g++) begin : g_ret
        assign ret_en[g]   = ret_en_flat[RETIRE_PORTS-1-g];
        assign ret_reg[g]  = ret_reg_flat[(RETIRE_PORTS-1-g)*AW +: AW];
        assign ret_data[g] = ret_data_flat[(RETIRE_PORTS-1-g)*DATA_W +: DATA_W];
        assign ret_tag[g]  = ret_tag_flat[(RETIRE_PORTS-1-g)*TAG_W +: TAG_W];
    end

    // Ascending port order makes the highest port win; allocation runs after retirement so it
    // overrides a busy clear on the same register.
    always_comb begin
        val_n  = val_q;
        busy_n = busy_q;
        own_n  = own_q;
        for (int i = 0; i < RETIRE_PORTS; i++) begin
            if (ret_en[i] && reg_ok[ret_reg[i]]) begin
                val_n[ret_reg[i]] = ret_data[i];
                if (own_q[ret_reg[i]] == ret_tag[i]) begin
                    busy_n[ret_reg[i]] = 1'b0;
                end
            end
        end
        if (flush) begin
            busy_n = '0;
        end else begin
            for (int j = 0; j < ALLOC_PORTS; j++) begin
                if (alloc_en[j] && reg_ok[alloc_reg[j]]) begin
                    busy_n[alloc_reg[j]] = 1'b1;
                    own_n[alloc_reg[j]]  = alloc_tag[j];
                end
            end
        end
    end

    always_comb begin
`ifdef RF_BYPASS_EN
        src_val  = val_n;
        src_busy = busy_n;
        src_own  = own_n;
`else
        src_val  = val_q;
        src_busy = busy_q;
        src_own  = own_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                val_q[r] <= '0;
                own_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_n;
            busy_q <= busy_n;
            own_q  <= own_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < READ_PORTS; k++) begin
                rd_value_q[k] <= '0;
                rd_owner_q[k] <= '0;
            end
            rd_busy_q <= '0;
        end else begin
            for (int k = 0; k < READ_PORTS; k++) begin
                if (reg_ok[rd_addr[k]]) begin
                    rd_value_q[k] <= src_val[rd_addr[k]];
                    rd_busy_q[k]  <= src_busy[rd_addr[k]];
                    rd_owner_q[k] <= src_own[rd_addr[k]];
                end else begin
                    rd_value_q[k] <= '0;
                    rd_busy_q[k]  <= 1'b0;
                    rd_owner_q[k] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tagged_register_file.sv
// Self-checking bench for tagged_register_file: directed scenarios plus randomized traffic
// against an array-based reference model. Follows RF_BYPASS_EN when defined.
module tb_tagged_register_file;

    localparam int NR = 16;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam int RP = 8;
    localparam int AP = 4;
    localparam int WP = 4;
    localparam int AW = 4;

    logic clk;
    logic rst;
    logic flush;
    logic [RP*AW-1:0] rd_addr_flat;
    logic [RP*DW-1:0] rd_value_flat;
    logic [RP-1:0]    rd_busy_flat;
    logic [RP*TW-1:0] rd_owner_flat;
    logic [AP-1:0]    alloc_en_flat;
    logic [AP*AW-1:0] alloc_reg_flat;
    logic [AP*TW-1:0] alloc_tag_flat;
    logic [WP-1:0]    ret_en_flat;
    logic [WP*AW-1:0] ret_reg_flat;
    logic [WP*DW-1:0] ret_data_flat;
    logic [WP*TW-1:0] ret_tag_flat;

    int checks;
    int failures;

    logic [DW-1:0] mval [NR];
    logic          mbusy [NR];
    logic [TW-1:0] mown [NR];
    logic [DW-1:0] exp_v [RP];
    logic          exp_b [RP];
    logic [TW-1:0] exp_o [RP];

    tagged_register_file dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rd_addr_flat(rd_addr_flat), .rd_value_flat(rd_value_flat),
        .rd_busy_flat(rd_busy_flat), .rd_owner_flat(rd_owner_flat),
        .alloc_en_flat(alloc_en_flat), .alloc_reg_flat(alloc_reg_flat),
        .alloc_tag_flat(alloc_tag_flat), .ret_en_flat(ret_en_flat),
        .ret_reg_flat(ret_reg_flat), .ret_data_flat(ret_data_flat),
        .ret_tag_flat(ret_tag_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] rd_val(int k);
        return rd_value_flat[(RP-1-k)*DW +: DW];
    endfunction

    function automatic logic rd_bsy(int k);
        return rd_busy_flat[RP-1-k];
    endfunction

    function automatic logic [TW-1:0] rd_own(int k);
        return rd_owner_flat[(RP-1-k)*TW +: TW];
    endfunction

    task automatic clear_inputs();
        flush = 1'b0;
        alloc_en_flat = '0; alloc_reg_flat = '0; alloc_tag_flat = '0;
        ret_en_flat = '0; ret_reg_flat = '0; ret_data_flat = '0; ret_tag_flat = '0;
    endtask

    task automatic set_alloc(int j, int r, int t);
        alloc_en_flat[AP-1-j] = 1'b1;
        alloc_reg_flat[(AP-1-j)*AW +: AW] = AW'(r);
        alloc_tag_flat[(AP-1-j)*TW +: TW] = TW'(t);
    endtask

    task automatic set_ret(int i, int r, int d, int t);
        ret_en_flat[WP-1-i] = 1'b1;
        ret_reg_flat[(WP-1-i)*AW +: AW] = AW'(r);
        ret_data_flat[(WP-1-i)*DW +: DW] = DW'(d);
        ret_tag_flat[(WP-1-i)*TW +: TW] = TW'(t);
    endtask

    task automatic set_rd(int k, int r);
        rd_addr_flat[(RP-1-k)*AW +: AW] = AW'(r);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            mval[r] = '0; mbusy[r] = 1'b0; mown[r] = '0;
        end
    endtask

    // Advances one edge; the model derives each register's next state directly from which
    // ports target it, and the expected read outputs from pre- or post-edge state.
    task automatic cycle();
        logic [DW-1:0] nv [NR];
        logic          nb [NR];
        logic [TW-1:0] no [NR];
        bit hit;
        for (int r = 0; r < NR; r++) begin
            nv[r] = mval[r]; nb[r] = mbusy[r]; no[r] = mown[r];
            for (int i = WP-1; i >= 0; i--) begin
                if (ret_en_flat[WP-1-i] && int'(ret_reg_flat[(WP-1-i)*AW +: AW]) == r) begin
                    nv[r] = ret_data_flat[(WP-1-i)*DW +: DW];
                    break;
                end
            end
            hit = 1'b0;
            if (!flush) begin
                for (int j = AP-1; j >= 0; j--) begin
                    if (alloc_en_flat[AP-1-j] && int'(alloc_reg_flat[(AP-1-j)*AW +: AW]) == r) begin
                        nb[r] = 1'b1;
                        no[r] = alloc_tag_flat[(AP-1-j)*TW +: TW];
                        hit = 1'b1;
                        break;
                    end
                end
            end
            if (!hit) begin
                if (flush) nb[r] = 1'b0;
                else begin
                    for (int i = 0; i < WP; i++) begin
                        if (ret_en_flat[WP-1-i] && int'(ret_reg_flat[(WP-1-i)*AW +: AW]) == r
                            && ret_tag_flat[(WP-1-i)*TW +: TW] == mown[r]) nb[r] = 1'b0;
                    end
                end
            end
        end
        for (int k = 0; k < RP; k++) begin
            int a;
            a = int'(rd_addr_flat[(RP-1-k)*AW +: AW]);
`ifdef RF_BYPASS_EN
            exp_v[k] = nv[a]; exp_b[k] = nb[a]; exp_o[k] = no[a];
`else
            exp_v[k] = mval[a]; exp_b[k] = mbusy[a]; exp_o[k] = mown[a];
`endif
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            mval[r] = nv[r]; mbusy[r] = nb[r]; mown[r] = no[r];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        rd_addr_flat = '0;
        model_reset();
        #1;
        checks++;
        if ({rd_value_flat, rd_busy_flat, rd_owner_flat} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got %h/%h/%h want 0", rd_value_flat, rd_busy_flat, rd_owner_flat);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        checks++;
        if ({rd_val(0), rd_bsy(0), rd_own(0)} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_read_r0 got %h/%b/%h want 0", rd_val(0), rd_bsy(0), rd_own(0));
        end
    endtask

    task automatic test_alloc_retire();
        clear_inputs(); set_alloc(0, 3, 7); cycle();
        clear_inputs(); set_ret(0, 3, 16'hBEEF, 7); cycle();
        clear_inputs();
        for (int k = 0; k < RP; k++) set_rd(k, 3);
        cycle();
        checks++;
        if ({rd_val(0), rd_bsy(0), rd_own(0)} !== {16'hBEEF, 1'b0, 4'd7}) begin
            failures++;
            $display("[TB] FAIL alloc_retire got %h/%b/%h want beef/0/7", rd_val(0), rd_bsy(0), rd_own(0));
        end
        checks++;
        if ({rd_val(7), rd_bsy(7), rd_own(7)} !== {16'hBEEF, 1'b0, 4'd7}) begin
            failures++;
            $display("[TB] FAIL alloc_retire_port7 got %h/%b/%h want beef/0/7", rd_val(7), rd_bsy(7), rd_own(7));
        end
    endtask

    task automatic test_stale_retire();
        clear_inputs(); set_alloc(1, 3, 7); cycle();
        clear_inputs(); set_alloc(2, 3, 9); cycle();
        clear_inputs(); set_ret(2, 3, 16'h1234, 7); cycle();
        clear_inputs(); set_rd(0, 3); cycle();
        checks++;
        if ({rd_val(0), rd_bsy(0), rd_own(0)} !== {16'h1234, 1'b1, 4'd9}) begin
            failures++;
            $display("[TB] FAIL stale_retire got %h/%b/%h want 1234/1/9", rd_val(0), rd_bsy(0), rd_own(0));
        end
    endtask

    task automatic test_same_edge();
        clear_inputs(); set_alloc(3, 2, 4); cycle();
        clear_inputs();
        set_ret(1, 2, 16'h2222, 4);
        set_alloc(0, 2, 6);
        set_ret(0, 1, 16'h1111, 0);
        set_ret(3, 1, 16'h3333, 0);
        cycle();
        clear_inputs(); set_rd(0, 2); set_rd(1, 1); cycle();
        checks++;
        if ({rd_val(0), rd_bsy(0), rd_own(0)} !== {16'h2222, 1'b1, 4'd6}) begin
            failures++;
            $display("[TB] FAIL retire_alloc_same got %h/%b/%h want 2222/1/6", rd_val(0), rd_bsy(0), rd_own(0));
        end
        checks++;
        if (rd_val(1) !== 16'h3333) begin
            failures++;
            $display("[TB] FAIL retire_priority got %h want 3333", rd_val(1));
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        for (int j = 0; j < AP; j++) set_alloc(j, j+1, j+1);
        cycle();
        clear_inputs(); flush = 1'b1; set_alloc(0, 5, 2); cycle();
        clear_inputs();
        for (int k = 0; k < 5; k++) set_rd(k, k+1);
        cycle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({rd_bsy(k), rd_own(k)} !== {1'b0, TW'(k+1)}) begin
                failures++;
                $display("[TB] FAIL flush_r%0d got busy %b owner %h want 0/%0d", k+1, rd_bsy(k), rd_own(k), k+1);
            end
        end
        checks++;
        if ({rd_bsy(4), rd_own(4)} !== {1'b0, 4'd0}) begin
            failures++;
            $display("[TB] FAIL flush_alloc_ignored got busy %b owner %h want 0/0", rd_bsy(4), rd_own(4));
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        clear_inputs(); set_ret(0, 8, 16'h5555, 0); cycle();
        clear_inputs(); set_rd(0, 8); set_ret(2, 8, 16'h00AA, 0); cycle();
`ifdef RF_BYPASS_EN
        want = 16'h00AA;
`else
        want = 16'h5555;
`endif
        checks++;
        if (rd_val(0) !== want) begin
            failures++;
            $display("[TB] FAIL same_cycle_read got %h want %h", rd_val(0), want);
        end
        clear_inputs(); cycle();
        checks++;
        if (rd_val(0) !== 16'h00AA) begin
            failures++;
            $display("[TB] FAIL next_cycle_read got %h want 00aa", rd_val(0));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            flush = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < AP; j++)
                if ($urandom_range(0, 1) == 1) set_alloc(j, $urandom_range(0, NR-1), $urandom_range(0, 15));
            for (int i = 0; i < WP; i++)
                if ($urandom_range(0, 1) == 1)
                    set_ret(i, $urandom_range(0, NR-1), $urandom_range(0, 65535), $urandom_range(0, 15));
            for (int k = 0; k < RP; k++) set_rd(k, $urandom_range(0, NR-1));
            cycle();
            for (int k = 0; k < RP; k++) begin
                checks++;
                if ({rd_val(k), rd_bsy(k), rd_own(k)} !== {exp_v[k], exp_b[k], exp_o[k]}) begin
                    failures++;
                    $display("[TB] FAIL random_c%0d_p%0d got %h/%b/%h want %h/%b/%h", n, k,
                             rd_val(k), rd_bsy(k), rd_own(k), exp_v[k], exp_b[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        clear_inputs(); set_alloc(0, 5, 3); set_ret(0, 5, 16'h0F0F, 1); cycle();
        clear_inputs();
        for (int k = 0; k < RP; k++) set_rd(k, 5);
        cycle();
        checks++;
        if ({rd_val(0), rd_bsy(0), rd_own(0)} !== {16'h0F0F, 1'b1, 4'd3}) begin
            failures++;
            $display("[TB] FAIL pre_reset_r5 got %h/%b/%h want 0f0f/1/3", rd_val(0), rd_bsy(0), rd_own(0));
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_value_flat, rd_busy_flat, rd_owner_flat} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset got %h/%h/%h want 0", rd_value_flat, rd_busy_flat, rd_owner_flat);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle();
        checks++;
        if ({rd_val(0), rd_bsy(0), rd_own(0)} !== '0) begin
            failures++;
            $display("[TB] FAIL post_reset_r5 got %h/%b/%h want 0/0/0", rd_val(0), rd_bsy(0), rd_own(0));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_alloc_retire();
        test_stale_retire();
        test_same_edge();
        test_flush();
        test_bypass();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
